nf_uart_receiver: RTL and testbench
===================================

Name: nf_uart_receiver

Overview:
UART receive block for the peripheral side of nf_top. It deserialises 8N1 frames from the uart_rx pin into bytes and holds them in a small show-ahead FIFO for the bus-side register interface. The bit period comes from a runtime divider: comp = work_freq / uart_speed, which is 434 at 50 MHz / 115200. Framing and overrun errors are reported as sticky flags.

Parameters:
FIFO_DEPTH, 4, receive FIFO depth in bytes; must be a power of 2 and at least 2.
COMP_W, 16, width of the bit-period divider input.

Ports:
clk  in  1  clock
resetn  in  1  reset; asynchronous, active-high
rec_en  in  1  receiver enable
comp  in  COMP_W  clocks per UART bit; must be at least 4
uart_rx  in  1  serial input; idles high
rx_data  out  8  byte at the FIFO head
rx_valid  out  1  FIFO not empty
rx_ready  in  1  pop request; a pop occurs when rx_valid and rx_ready are both high
fifo_full  out  1  FIFO holds FIFO_DEPTH bytes
frame_err  out  1  sticky: a stop bit was sampled low
overrun_err  out  1  sticky: a byte was dropped because the FIFO was full
err_clr  in  1  single-cycle clear of both sticky flags

Behaviour:
- Reset values: rx_data 0x00, rx_valid 0, fifo_full 0, frame_err 0, overrun_err 0. FSM resets to IDLE. Counters and pointers reset to 0. Both synchroniser flops reset to 1.
- uart_rx passes through a 2-flop synchroniser giving rx_s. rx_s_d is rx_s delayed one cycle. All sampling uses rx_s.
- States: IDLE, START, DATA, STOP. There is one bit counter (cnt, COMP_W bits) and one bit index (idx, 3 bits).
- IDLE:
  - Moves to START when rec_en = 1 and a falling edge is seen (rx_s_d = 1, rx_s = 0).
  - On entry to START: comp is latched into comp_l, and cnt is set to 0. Changes on comp mid-frame are ignored.
- START:
  - cnt increments each cycle.
  - When cnt = (comp_l >> 1) - 1, rx_s is sampled and cnt is set to 0.
  - If the sample is 1, it is a false start: return to IDLE.
  - If the sample is 0, go to DATA with idx = 0.
- DATA:
  - When cnt = comp_l - 1, shift rx_s in LSB first (shreg <= {rx_s, shreg[7:1]}) and set cnt to 0.
  - When idx = 7, go to STOP; otherwise idx increments.
- STOP:
  - When cnt = comp_l - 1, sample rx_s and return to IDLE in the same cycle.
  - Sample 1 with FIFO not full: push shreg into the FIFO.
  - Sample 1 with FIFO full and no pop this cycle: drop the byte and set overrun_err.
  - Sample 1 with FIFO full and a simultaneous pop: push is accepted and no error is raised.
  - Sample 0: drop the byte and set frame_err. IDLE still requires a fresh falling edge, so a held break line never starts a new frame.
- Latency: rx_valid goes high one cycle after the stop-bit sample cycle. A stop sample lands about 9.5 × comp cycles after the start edge plus 2 synchroniser cycles.
- Back-to-back frames: returning to IDLE at mid-stop-bit lets the next start edge be caught with no gap.
- rec_en deasserted in START, DATA or STOP: abort to IDLE and discard the partial byte. FIFO contents and error flags are kept.
- FIFO:
  - Show-ahead: rx_data is always mem[rd_ptr]; rx_valid = (count != 0).
  - Pointers wrap modulo FIFO_DEPTH. count is log2(FIFO_DEPTH)+1 bits wide.
  - Pop when empty has no effect.
  - Simultaneous push and pop leaves count unchanged.
- Error flags:
  - err_clr clears both flags.
  - A new error in the same cycle as err_clr wins: the flag is set.
- Reset mid-frame: all state returns to reset values immediately. No byte is pushed.

Decomposition:
- Package nf_uart_pkg holds:
  - typedef enum logic [1:0] { IDLE, START, DATA, STOP } uart_rx_st_t
  - localparam UART_DATA_W = 8
  - the default comp constant 434
- Sub-module nf_uart_rx_fifo: a parameterised show-ahead FIFO with push, pop, full, empty and count. The top keeps the synchroniser, FSM, counters and error flags.

Test Plan:
All scenarios use comp = 434 and rx_ready = 1 unless stated. Frames are generated by the existing bench send_uart_symbol task.
1. Send 0x48 → exactly one rx_valid pulse with rx_data = 0x48. It appears no later than 10 × 434 + 4 cycles after the start edge. frame_err = 0.
2. Send "Hello World!" with 100 ns gaps → 12 bytes popped in order: 0x48 0x65 0x6C 0x6C 0x6F 0x20 0x57 0x6F 0x72 0x6C 0x64 0x21. No errors.
3. Pull uart_rx low for 100 clocks, then high → false start. FSM is back in IDLE within 220 cycles, rx_valid stays 0, and a following 0x55 frame is received correctly.
4. Send 0xA5 with the stop bit forced to 0 → no push and frame_err = 1. Pulse err_clr → frame_err = 0. A following 0x3C is received correctly.
5. Hold rx_ready = 0 and send 0x01..0x05 → fifo_full = 1 after the 4th byte, and overrun_err = 1 at the 5th stop sample. Popping then yields 0x01..0x04 and rx_valid falls.
6. Assert resetn mid-DATA of 0xFF → all outputs take reset values. Release resetn and send 0x81 → rx_data = 0x81 with no stale bits.

Source files
------------

// File: rtl/nf_uart_pkg.sv
// rtl/nf_uart_pkg.sv - shared types and constants for the UART receive path
package nf_uart_pkg;

    typedef enum logic [1:0] { IDLE, START, DATA, STOP } uart_rx_st_t;

    localparam int UART_DATA_W       = 8;
    localparam int UART_DEFAULT_COMP = 434;

endpackage

// File: rtl/nf_uart_rx_fifo.sv
// rtl/nf_uart_rx_fifo.sv - show-ahead byte FIFO holding received UART data
module nf_uart_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is accepted only when a pop frees a slot in the same cycle
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (do_push && !do_pop) begin
                count <= count + 1'b1;
            end else if (do_pop && !do_push) begin
                count <= count - 1'b1;
            end
        end
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (count == (AW+1)'(DEPTH));
    assign empty   = (count == '0);

endmodule

// File: rtl/nf_uart_receiver.sv
// rtl/nf_uart_receiver.sv - 8N1 UART receiver with runtime bit divider, FIFO and sticky errors
module nf_uart_receiver
    import nf_uart_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int COMP_W     = 16
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              rec_en,
    input  logic [COMP_W-1:0] comp,
    input  logic              uart_rx,
    output logic [7:0]        rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              fifo_full,
    output logic              frame_err,
    output logic              overrun_err,
    input  logic              err_clr
);

    logic                      rx_meta, rx_s, rx_s_d;
    uart_rx_st_t               state, state_n;
    logic [COMP_W-1:0]         cnt, cnt_n, comp_l, comp_l_n;
    logic [2:0]                idx, idx_n;
    logic [UART_DATA_W-1:0]    shreg, shreg_n;
    logic                      push, pop, frame_set, overrun_set;
    logic                      half_hit, bit_hit;
    logic                      fifo_empty;
    logic [$clog2(FIFO_DEPTH):0] fifo_count;

    assign half_hit = (cnt == (comp_l >> 1) - 1'b1);
    assign bit_hit  = (cnt == comp_l - 1'b1);
    assign pop      = rx_ready && !fifo_empty;
    assign rx_valid = (fifo_count != '0);

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            rx_meta     <= 1'b1;
            rx_s        <= 1'b1;
            rx_s_d      <= 1'b1;
            state       <= IDLE;
            cnt         <= '0;
            comp_l      <= '0;
            idx         <= '0;
            shreg       <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            rx_meta     <= uart_rx;
            rx_s        <= rx_meta;
            rx_s_d      <= rx_s;
            state       <= state_n;
            cnt         <= cnt_n;
            comp_l      <= comp_l_n;
            idx         <= idx_n;
            shreg       <= shreg_n;
            frame_err   <= frame_set   | (frame_err   & ~err_clr);
            overrun_err <= overrun_set | (overrun_err & ~err_clr);
        end
    end

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        comp_l_n    = comp_l;
        idx_n       = idx;
        shreg_n     = shreg;
        push        = 1'b0;
        frame_set   = 1'b0;
        overrun_set = 1'b0;
        case (state)
            IDLE: begin
                if (rec_en && rx_s_d && !rx_s) begin
                    state_n  = START;
                    comp_l_n = comp;
                    cnt_n    = '0;
                end
            end
            START: begin
                if (half_hit) begin
                    cnt_n = '0;
                    if (rx_s) begin
                        state_n = IDLE;
                    end else begin
                        state_n = DATA;
                        idx_n   = '0;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            DATA: begin
                if (bit_hit) begin
                    cnt_n   = '0;
                    shreg_n = {rx_s, shreg[UART_DATA_W-1:1]};
                    if (idx == 3'd7) begin
                        state_n = STOP;
                    end else begin
                        idx_n = idx + 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            STOP: begin
                // Leave at mid-stop-bit so a back-to-back start edge is not missed
                if (bit_hit) begin
                    state_n = IDLE;
                    cnt_n   = '0;
                    if (!rx_s) begin
                        frame_set = 1'b1;
                    end else if (!fifo_full || pop) begin
                        push = 1'b1;
                    end else begin
                        overrun_set = 1'b1;
                    end
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
        if (state != IDLE && !rec_en) begin
            state_n     = IDLE;
            cnt_n       = '0;
            push        = 1'b0;
            frame_set   = 1'b0;
            overrun_set = 1'b0;
        end
    end

    nf_uart_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (UART_DATA_W)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (shreg),
        .pop       (pop),
        .rd_data   (rx_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

endmodule

// File: tb/tb_nf_uart_receiver.sv
// tb/tb_nf_uart_receiver.sv - randomized self-checking bench for nf_uart_receiver
module tb_nf_uart_receiver;
    import nf_uart_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn = 1'b1;
    logic        rec_en = 1'b0;
    logic [15:0] comp = 16'(UART_DEFAULT_COMP);
    logic        uart_rx = 1'b1;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready = 1'b1;
    logic        fifo_full;
    logic        frame_err;
    logic        overrun_err;
    logic        err_clr = 1'b0;

    int          errors = 0;
    int          checks = 0;
    logic [7:0]  exp_q[$];
    logic [7:0]  log_q[$];
    bit          exp_frame = 1'b0;
    bit          exp_over = 1'b0;

    nf_uart_receiver #(.FIFO_DEPTH(DEPTH), .COMP_W(16)) dut (
        .clk         (clk),
        .resetn      (resetn),
        .rec_en      (rec_en),
        .comp        (comp),
        .uart_rx     (uart_rx),
        .rx_data     (rx_data),
        .rx_valid    (rx_valid),
        .rx_ready    (rx_ready),
        .fifo_full   (fifo_full),
        .frame_err   (frame_err),
        .overrun_err (overrun_err),
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Model: bytes the bench expects to read, in order; the FIFO head must always match
    always @(negedge clk) begin
        if (!resetn && rx_valid) begin
            check("valid_has_expected_byte", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                check("rx_data_head", 32'(rx_data), 32'(exp_q[0]));
                if (rx_ready) begin
                    log_q.push_back(rx_data);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    task automatic cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_bits(input logic [9:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            uart_rx = bits[i];
            cycles(int'(comp));
        end
    endtask

    task automatic check_flags();
        check("frame_err", 32'(frame_err), 32'(exp_frame));
        check("overrun_err", 32'(overrun_err), 32'(exp_over));
        check("fifo_full", 32'(fifo_full), 32'(exp_q.size() == DEPTH));
        if (rx_ready) check("fifo_drained", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop, input int gap);
        if (!stop) exp_frame = 1'b1;
        else if (exp_q.size() < DEPTH) exp_q.push_back(b);
        else exp_over = 1'b1;
        send_bits({stop, b, 1'b0}, 10);
        uart_rx = 1'b1;
        cycles(6);
        check_flags();
        cycles(gap);
    endtask

    task automatic clear_errs();
        err_clr = 1'b1;
        cycles(1);
        err_clr = 1'b0;
        exp_frame = 1'b0;
        exp_over = 1'b0;
        check("frame_err_cleared", 32'(frame_err), 32'd0);
        check("overrun_err_cleared", 32'(overrun_err), 32'd0);
    endtask

    task automatic check_reset_outputs();
        check("rst_rx_data", 32'(rx_data), 32'd0);
        check("rst_rx_valid", 32'(rx_valid), 32'd0);
        check("rst_fifo_full", 32'(fifo_full), 32'd0);
        check("rst_frame_err", 32'(frame_err), 32'd0);
        check("rst_overrun_err", 32'(overrun_err), 32'd0);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        string      hello;
        logic [7:0] hello_ref [12];
        logic [7:0] rb;
        bit         rs;
        int         n;
        bit         seen;

        hello = "Hello World!";
        hello_ref = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                      8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

        cycles(3);
        check_reset_outputs();
        resetn = 1'b0;
        rec_en = 1'b1;
        cycles(2);

        // Single byte with latency bound from the start edge
        log_q.delete();
        fork
            send_frame(8'h48, 1'b1, 4);
            begin
                n = 0;
                seen = 1'b0;
                while (!seen && n < 5000) begin
                    @(posedge clk);
                    #1;
                    n++;
                    if (rx_valid) seen = 1'b1;
                end
                check("t1_latency_bound", 32'(seen && n <= 10 * 434 + 4), 32'd1);
            end
        join
        check("t1_count", 32'(log_q.size()), 32'd1);
        check("t1_byte", 32'(log_q[0]), 32'h48);

        comp = 16'd32;
        log_q.delete();
        for (int i = 0; i < 12; i++) send_frame(8'(hello[i]), 1'b1, 4);
        check("t2_count", 32'(log_q.size()), 32'd12);
        for (int i = 0; i < 12; i++) check("t2_hello_byte", 32'(log_q[i]), 32'(hello_ref[i]));

        comp = 16'd434;
        log_q.delete();
        uart_rx = 1'b0;
        cycles(100);
        uart_rx = 1'b1;
        cycles(130);
        check("t3_no_byte", 32'(rx_valid), 32'd0);
        send_frame(8'h55, 1'b1, 4);
        check("t3_count", 32'(log_q.size()), 32'd1);
        check("t3_byte", 32'(log_q[0]), 32'h55);

        log_q.delete();
        send_frame(8'hA5, 1'b0, 4);
        check("t4_no_push", 32'(log_q.size()), 32'd0);
        clear_errs();
        send_frame(8'h3C, 1'b1, 4);
        check("t4_byte", 32'(log_q[0]), 32'h3C);

        comp = 16'd20;
        rx_ready = 1'b0;
        log_q.delete();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b1, 2);
        check("t5_overrun", 32'(overrun_err), 32'd1);
        rx_ready = 1'b1;
        n = 0;
        while (rx_valid && n < 20) begin
            cycles(1);
            n++;
        end
        check("t5_valid_falls", 32'(rx_valid), 32'd0);
        check("t5_count", 32'(log_q.size()), 32'd4);
        for (int i = 0; i < 4; i++) check("t5_byte", 32'(log_q[i]), 32'(i + 1));
        clear_errs();

        for (int i = 0; i < 30; i++) begin
            comp = 16'($urandom_range(8, 40));
            rb = 8'($urandom);
            if ($urandom_range(0, 7) == 0) begin
                send_bits({1'b1, rb, 1'b0}, int'($urandom_range(1, 8)));
                rec_en = 1'b0;
                cycles(2);
                uart_rx = 1'b1;
                cycles(3);
                rec_en = 1'b1;
                cycles(2);
                check_flags();
            end else begin
                rs = ($urandom_range(0, 5) != 0);
                send_frame(rb, rs, int'($urandom_range(0, 4)));
                if (exp_frame && $urandom_range(0, 1) == 1) clear_errs();
            end
        end
        if (exp_frame) clear_errs();

        // Reset in the middle of a frame, then a clean frame
        comp = 16'd434;
        log_q.delete();
        send_bits({1'b1, 8'hFF, 1'b0}, 5);
        #2;
        resetn = 1'b1;
        #1;
        check_reset_outputs();
        exp_q.delete();
        exp_frame = 1'b0;
        exp_over = 1'b0;
        uart_rx = 1'b1;
        cycles(3);
        resetn = 1'b0;
        cycles(2);
        send_frame(8'h81, 1'b1, 4);
        check("t6_count", 32'(log_q.size()), 32'd1);
        check("t6_byte", 32'(log_q[0]), 32'h81);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
